// File: rtl/shot_turn_controller.sv
// Pool game-flow sequencer: gates cue aiming, fires the shot, waits for the table to
// settle, then scores the balls pocketed during the shot and decides whose turn is next.
module shot_turn_controller #(
  parameter int unsigned MIN_ROLL_CYCLES = 2_000_000,
  parameter int unsigned SETTLE_CYCLES   = 1_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       shoot_req_i,
  input  logic       new_game_i,
  input  logic       balls_have_stoped_i,
  input  logic [3:0] pocket_hit_i,
  output logic       aim_enable_o,
  output logic       shot_fire_o,
  output logic       cue_respawn_o,
  output logic       balls_reset_o,
  output logic       current_player_o,
  output logic [1:0] score_p0_o,
  output logic [1:0] score_p1_o,
  output logic       game_over_o,
  output logic       winner_o,
  output logic [2:0] state_dbg_o
);

  typedef enum logic [2:0] {
    ST_AIM    = 3'd0,
    ST_FIRE   = 3'd1,
    ST_ROLL   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_EVAL   = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  localparam logic [31:0] ROLL_MAX   = 32'(MIN_ROLL_CYCLES);
  localparam logic [31:0] SETTLE_MAX = 32'(SETTLE_CYCLES);

  state_t      state_q;
  logic [31:0] roll_cnt_q;
  logic [31:0] roll_cnt_d;
  logic [31:0] settle_cnt_q;
  logic        shoot_prev_q;
  logic [3:0]  shot_pocket_q;
  logic [3:0]  shot_pocket_d;
  logic [3:1]  pocketed_mask_q;
  logic [1:0]  score_p0_q;
  logic [1:0]  score_p1_q;
  logic [1:0]  score_p0_d;
  logic [1:0]  score_p1_d;
  logic        player_q;
  logic        winner_q;
  logic        aim_enable_q;
  logic        shot_fire_q;
  logic        cue_respawn_q;
  logic        balls_reset_q;
  logic        game_over_q;

  logic        shoot_edge;
  logic        capture_en;
  logic [3:0]  pocket_new;
  logic [1:0]  sunk_n;
  logic [2:0]  total_d;
  logic        foul;

  always_comb begin
    shoot_edge    = shoot_req_i & ~shoot_prev_q;
    capture_en    = (state_q == ST_FIRE) || (state_q == ST_ROLL) || (state_q == ST_SETTLE);
    // Object balls already off the table cannot be credited twice.
    pocket_new    = pocket_hit_i & {~pocketed_mask_q, 1'b1};
    shot_pocket_d = (state_q == ST_FIRE) ? pocket_new : (shot_pocket_q | pocket_new);
    roll_cnt_d    = (roll_cnt_q >= ROLL_MAX) ? ROLL_MAX : (roll_cnt_q + 32'd1);
    sunk_n        = {1'b0, shot_pocket_q[1]} + {1'b0, shot_pocket_q[2]} + {1'b0, shot_pocket_q[3]};
    foul          = shot_pocket_q[0];
    score_p0_d    = score_p0_q + (player_q ? 2'd0 : sunk_n);
    score_p1_d    = score_p1_q + (player_q ? sunk_n : 2'd0);
    total_d       = {1'b0, score_p0_d} + {1'b0, score_p1_d};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= ST_AIM;
      roll_cnt_q      <= '0;
      settle_cnt_q    <= '0;
      shoot_prev_q    <= 1'b0;
      shot_pocket_q   <= '0;
      pocketed_mask_q <= '0;
      score_p0_q      <= '0;
      score_p1_q      <= '0;
      player_q        <= 1'b0;
      winner_q        <= 1'b0;
      aim_enable_q    <= 1'b1;
      shot_fire_q     <= 1'b0;
      cue_respawn_q   <= 1'b0;
      balls_reset_q   <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      shoot_prev_q  <= shoot_req_i;
      shot_fire_q   <= 1'b0;
      cue_respawn_q <= 1'b0;
      balls_reset_q <= 1'b0;
      if (capture_en) shot_pocket_q <= shot_pocket_d;

      case (state_q)
        ST_AIM: begin
          if (shoot_edge) begin
            state_q      <= ST_FIRE;
            shot_fire_q  <= 1'b1;
            aim_enable_q <= 1'b0;
          end
        end
        ST_FIRE: begin
          roll_cnt_q <= '0;
          state_q    <= ST_ROLL;
        end
        ST_ROLL: begin
          roll_cnt_q <= roll_cnt_d;
          if ((roll_cnt_d == ROLL_MAX) && balls_have_stoped_i) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= 32'd1;
          end
        end
        ST_SETTLE: begin
          // Any moving ball restarts the settle window, even on its last cycle.
          if (!balls_have_stoped_i) begin
            settle_cnt_q <= '0;
          end else if (settle_cnt_q >= SETTLE_MAX) begin
            state_q       <= ST_EVAL;
            cue_respawn_q <= shot_pocket_d[0];
          end else begin
            settle_cnt_q <= settle_cnt_q + 32'd1;
          end
        end
        ST_EVAL: begin
          pocketed_mask_q <= pocketed_mask_q | shot_pocket_q[3:1];
          score_p0_q      <= score_p0_d;
          score_p1_q      <= score_p1_d;
          if (total_d == 3'd3) begin
            state_q     <= ST_OVER;
            game_over_q <= 1'b1;
            winner_q    <= (score_p1_d > score_p0_d);
          end else begin
            state_q      <= ST_AIM;
            aim_enable_q <= 1'b1;
            if (foul || (sunk_n == 2'd0)) player_q <= ~player_q;
          end
        end
        ST_OVER: begin
          if (new_game_i) begin
            state_q         <= ST_AIM;
            score_p0_q      <= '0;
            score_p1_q      <= '0;
            pocketed_mask_q <= '0;
            player_q        <= 1'b0;
            balls_reset_q   <= 1'b1;
            game_over_q     <= 1'b0;
            aim_enable_q    <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_AIM;
          aim_enable_q <= 1'b1;
        end
      endcase
    end
  end

  assign aim_enable_o     = aim_enable_q;
  assign shot_fire_o      = shot_fire_q;
  assign cue_respawn_o    = cue_respawn_q;
  assign balls_reset_o    = balls_reset_q;
  assign current_player_o = player_q;
  assign score_p0_o       = score_p0_q;
  assign score_p1_o       = score_p1_q;
  assign game_over_o      = game_over_q;
  assign winner_o         = winner_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_shot_turn_controller.sv
// Bench for shot_turn_controller: cycle-exact vector table for the first shots, hand
// sequences for settle restart, game over and reset, then random shots vs a game model.
module tb_shot_turn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       shoot_req;
  logic       new_game;
  logic       stopped;
  logic [3:0] pocket_hit;
  logic       aim_enable, shot_fire, cue_respawn, balls_reset;
  logic       current_player, game_over, winner;
  logic [1:0] score_p0, score_p1;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // Game-level reference model: one update per completed shot.
  int       m_score[2];
  int       m_player;
  bit [3:1] m_mask;
  bit       m_over;
  bit       m_winner;

  typedef struct {
    logic       shoot;
    logic       stop;
    logic [3:0] pocket;
    logic [2:0] st;
    logic       fire;
    logic       aim;
    logic       player;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  shot_turn_controller #(.MIN_ROLL_CYCLES(4), .SETTLE_CYCLES(3)) dut (
    .clk_i               (clk),
    .reset_i             (rst),
    .shoot_req_i         (shoot_req),
    .new_game_i          (new_game),
    .balls_have_stoped_i (stopped),
    .pocket_hit_i        (pocket_hit),
    .aim_enable_o        (aim_enable),
    .shot_fire_o         (shot_fire),
    .cue_respawn_o       (cue_respawn),
    .balls_reset_o       (balls_reset),
    .current_player_o    (current_player),
    .score_p0_o          (score_p0),
    .score_p1_o          (score_p1),
    .game_over_o         (game_over),
    .winner_o            (winner),
    .state_dbg_o         (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sh, input logic sp, input logic [3:0] pk,
                              input logic [2:0] st, input logic fr, input logic am,
                              input logic pl);
    vec_t v;
    v.shoot = sh; v.stop = sp; v.pocket = pk; v.st = st;
    v.fire = fr; v.aim = am; v.player = pl;
    return v;
  endfunction

  task automatic model_reset();
    m_score[0] = 0; m_score[1] = 0; m_player = 0; m_mask = '0; m_over = 1'b0;
  endtask

  task automatic model_shot(input logic [3:0] hit);
    bit [3:1] nb;
    int n;
    nb = hit[3:1] & ~m_mask;
    n  = $countones(nb);
    m_score[m_player] += n;
    m_mask |= nb;
    if (m_score[0] + m_score[1] == 3) begin
      m_over   = 1'b1;
      m_winner = (m_score[1] > m_score[0]);
    end else if (hit[0] || n == 0) begin
      m_player = 1 - m_player;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_state"}, state_dbg, m_over ? 5 : 0);
    chk({tag, "_score_p0"}, score_p0, m_score[0]);
    chk({tag, "_score_p1"}, score_p1, m_score[1]);
    chk({tag, "_player"}, current_player, m_player);
    chk({tag, "_game_over"}, game_over, m_over);
    chk({tag, "_aim"}, aim_enable, m_over ? 0 : 1);
    if (m_over) chk({tag, "_winner"}, winner, m_winner);
  endtask

  // One full shot from AIM: stray inputs while aiming, press, one pocket pulse at
  // offset 'off' after the fire cycle (always inside the capture window).
  task automatic do_shot(input string tag, input logic [3:0] hit, input int off,
                         input logic [3:0] stray, input bit glitch, input bit hold);
    int  fires, resp, brs, cyc;
    bit  done;
    shoot_req = 1'b0; pocket_hit = stray; new_game = stray[3]; stopped = 1'b1;
    step();
    chk({tag, "_idle_aim"}, state_dbg, 0);
    pocket_hit = '0; new_game = 1'b0; shoot_req = 1'b1;
    step();
    chk({tag, "_fire_state"}, state_dbg, 1);
    fires = shot_fire; resp = cue_respawn; brs = balls_reset;
    shoot_req = hold;
    done = 1'b0; cyc = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      pocket_hit = (k == off) ? hit : 4'b0000;
      stopped    = glitch ? ($urandom_range(0, 4) != 0) : 1'b1;
      step();
      fires += shot_fire; resp += cue_respawn; brs += balls_reset; cyc++;
      if (state_dbg == 3'd0 || state_dbg == 3'd5) done = 1'b1;
    end
    pocket_hit = '0; stopped = 1'b1;
    chk({tag, "_completed"}, done, 1);
    model_shot(hit);
    chk({tag, "_fire_count"}, fires, 1);
    chk({tag, "_respawn_count"}, resp, hit[0]);
    chk({tag, "_balls_reset_count"}, brs, 0);
    check_model(tag);
    step();
    chk({tag, "_no_refire"}, state_dbg, m_over ? 5 : 0);
    $display("shot %s hit=%b off=%0d cycles=%0d p0=%0d p1=%0d player=%0d over=%0d",
             tag, hit, off, cyc, score_p0, score_p1, current_player, game_over);
  endtask

  task automatic restart_game(input string tag);
    int brs;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    brs = balls_reset;
    for (int k = 0; k < 3; k++) begin
      step();
      brs += balls_reset;
    end
    model_reset();
    chk({tag, "_balls_reset_pulses"}, brs, 1);
    check_model(tag);
    $display("new game %s p0=%0d p1=%0d player=%0d", tag, score_p0, score_p1, current_player);
  endtask

  initial begin
    int cnt, strobes;
    bit done;

    // First shot: P0 fires with the key held throughout, nothing pocketed.
    tbl[0]  = mk(1, 1, 4'h0, 3'd1, 1, 0, 0);
    tbl[1]  = mk(1, 1, 4'h0, 3'd2, 0, 0, 0);
    tbl[2]  = mk(1, 1, 4'h0, 3'd2, 0, 0, 0);
    tbl[3]  = mk(1, 1, 4'h0, 3'd2, 0, 0, 0);
    tbl[4]  = mk(1, 1, 4'h0, 3'd2, 0, 0, 0);
    tbl[5]  = mk(1, 1, 4'h0, 3'd3, 0, 0, 0);
    tbl[6]  = mk(1, 1, 4'h0, 3'd3, 0, 0, 0);
    tbl[7]  = mk(1, 1, 4'h0, 3'd3, 0, 0, 0);
    tbl[8]  = mk(1, 1, 4'h0, 3'd4, 0, 0, 0);
    tbl[9]  = mk(1, 1, 4'h0, 3'd0, 0, 1, 1);
    tbl[10] = mk(1, 1, 4'h2, 3'd0, 0, 1, 1);
    tbl[11] = mk(0, 1, 4'h0, 3'd0, 0, 1, 1);
    // Fresh press: P1 shot, nothing pocketed, turn returns to P0.
    tbl[12] = mk(1, 1, 4'h0, 3'd1, 1, 0, 1);
    tbl[13] = mk(0, 1, 4'h0, 3'd2, 0, 0, 1);
    tbl[14] = mk(0, 1, 4'h0, 3'd2, 0, 0, 1);
    tbl[15] = mk(0, 1, 4'h0, 3'd2, 0, 0, 1);
    tbl[16] = mk(0, 1, 4'h0, 3'd2, 0, 0, 1);
    tbl[17] = mk(0, 1, 4'h0, 3'd3, 0, 0, 1);
    tbl[18] = mk(0, 1, 4'h0, 3'd3, 0, 0, 1);
    tbl[19] = mk(0, 1, 4'h0, 3'd3, 0, 0, 1);
    tbl[20] = mk(0, 1, 4'h0, 3'd4, 0, 0, 1);
    tbl[21] = mk(0, 1, 4'h0, 3'd0, 0, 1, 0);

    rst = 1'b1; shoot_req = 1'b0; new_game = 1'b0; stopped = 1'b1; pocket_hit = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;

    chk("reset_state", state_dbg, 0);
    chk("reset_aim", aim_enable, 1);
    chk("reset_fire", shot_fire, 0);
    chk("reset_respawn", cue_respawn, 0);
    chk("reset_balls_reset", balls_reset, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_player", current_player, 0);
    chk("reset_scores", {score_p1, score_p0}, 0);

    for (int i = 0; i < NV; i++) begin
      shoot_req = tbl[i].shoot; stopped = tbl[i].stop; pocket_hit = tbl[i].pocket;
      step();
      chk($sformatf("vec%0d_state", i), state_dbg, tbl[i].st);
      chk($sformatf("vec%0d_fire", i), shot_fire, tbl[i].fire);
      chk($sformatf("vec%0d_aim", i), aim_enable, tbl[i].aim);
      chk($sformatf("vec%0d_player", i), current_player, tbl[i].player);
      $display("vector %0d state=%0d fire=%0d aim=%0d player=%0d",
               i, state_dbg, shot_fire, aim_enable, current_player);
    end
    pocket_hit = '0;
    chk("table_scores", {score_p1, score_p0}, 0);

    // Settle restart: two stopped SETTLE cycles, one moving cycle, then stopped again.
    shoot_req = 1'b1;
    step();
    chk("drop_fire_state", state_dbg, 1);
    shoot_req = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (state_dbg == 3'd3) done = 1'b1;
    end
    chk("drop_reached_settle", done, 1);
    step();
    step();
    chk("drop_pre_settle", state_dbg, 3);
    stopped = 1'b0;
    step();
    chk("drop_moving_settle", state_dbg, 3);
    stopped = 1'b1;
    cnt = 0; done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      step();
      cnt++;
      if (state_dbg == 3'd4) done = 1'b1;
    end
    chk("drop_settle_restart_cycles", cnt, 4);
    step();
    model_shot(4'b0000);
    check_model("drop_after");
    $display("shot drop player=%0d cycles_after_drop=%0d", current_player, cnt);

    do_shot("p1_blank", 4'b0000, 1, 4'b0000, 0, 0);
    do_shot("p0_two", 4'b0110, 2, 4'b0001, 0, 1);
    chk("p0_two_score", score_p0, 2);
    chk("p0_two_player", current_player, 0);
    do_shot("p0_repeat", 4'b0010, 1, 4'b0000, 0, 0);
    chk("p0_repeat_score", score_p0, 2);
    do_shot("p1_cue_only", 4'b0001, 3, 4'b1000, 0, 0);
    chk("p1_cue_only_player", current_player, 0);
    do_shot("p0_blank", 4'b0000, 0, 4'b0100, 0, 0);
    do_shot("p1_foul_last", 4'b1001, 3, 4'b0000, 0, 0);
    chk("over_winner_p0", winner, 0);
    chk("over_game_over", game_over, 1);

    // Stray pockets and presses in OVER change nothing.
    pocket_hit = 4'b1111; shoot_req = 1'b1;
    step();
    pocket_hit = '0; shoot_req = 1'b0;
    step();
    step();
    check_model("over_stray");
    restart_game("ng1");

    for (int s = 0; s < 40; s++) begin
      if (m_over) restart_game($sformatf("ng_r%0d", s));
      do_shot($sformatf("rnd%0d", s), 4'($urandom_range(0, 15)), $urandom_range(0, 4),
              4'($urandom_range(0, 15)), 1, 1'($urandom_range(0, 1)));
    end
    if (m_over) restart_game("ng_final");

    // Reset in ROLL aborts the shot without any strobe.
    do_shot("pre_reset", 4'b0100, 1, 4'b0000, 0, 0);
    shoot_req = 1'b1;
    step();
    shoot_req = 1'b0;
    step();
    step();
    chk("rst_roll_state", state_dbg, 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_state", state_dbg, 0);
    chk("rst_async_aim", aim_enable, 1);
    chk("rst_async_strobes", {shot_fire, cue_respawn, balls_reset}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model("rst_after");
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      strobes += shot_fire + cue_respawn + balls_reset;
    end
    chk("rst_no_strobes", strobes, 0);
    chk("rst_idle_state", state_dbg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
